// File: rtl/fetch_hazard_ctrl.sv
// ============================================================================
// fetch_hazard_ctrl
// ----------------------------------------------------------------------------
// Front-end hazard controller for the 5-stage core. Each cycle it turns the
// redirect sources (EX branch/JALR, ID JAL), the load-use interlock and an
// external freeze into PC / IF-ID / ID-EX control strobes. The IROM has a
// 1-cycle read latency, so every redirect kills two fetch slots: the slot
// fetched in the redirect cycle, and the stale IROM word in the next cycle
// (FLUSH state).
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   id_rs1_i, id_rs2_i    source registers of the ID instruction
//   id_use_rs1_i/_rs2_i   ID instruction really reads rs1 / rs2
//   ex_rd_i               destination register of the EX instruction
//   ex_mem_read_i         EX instruction is a load
//   ex_redirect_i         EX resolved a taken branch / JALR
//   ex_target_i           EX redirect target
//   id_jal_i              ID holds a JAL
//   id_jal_target_i       JAL target
//   ext_stall_i           freeze the whole front end
//   pc_we_o               PC register load enable
//   pc_sel_o              next PC: 0 = sequential, 1 = redirect_pc_o
//   redirect_pc_o         redirect address
//   if_id_we_o            IF/ID write enable
//   if_id_flush_o         IF/ID loads a bubble
//   id_ex_flush_o         ID/EX loads a bubble
//
// Optional feature (macro FETCH_HAZARD_PERF_EN):
//   stall_cycles_o        saturating count of cycles with pc_we_o = 0
//   flush_cycles_o        saturating count of cycles with if_id_flush_o = 1
// ============================================================================
module fetch_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        id_jal_i,
    input  logic [31:0] id_jal_target_i,
    input  logic        ext_stall_i,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic [31:0] redirect_pc_o,
    output logic        if_id_we_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o
`ifdef FETCH_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_cycles_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        load_use;

    // x0 is never a real producer, so a load to x0 must not interlock.
    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Per-cycle arbitration. Priority: freeze > pending redirect > EX
    // redirect > (FLUSH kill slot) > load-use > JAL > sequential.
    // In FLUSH the ID slot holds a bubble, so load-use and JAL are ignored
    // there; only a fresh EX redirect can override the kill slot.
    // A redirect arriving while frozen is parked in pend_* and replayed on
    // the first unfrozen cycle; the earliest one is kept since anything
    // after it is wrong-path.
    always_comb begin
        state_d       = state_q;
        pend_v_d      = pend_v_q;
        pend_pc_d     = pend_pc_q;
        pc_we_o       = 1'b1;
        pc_sel_o      = 2'd0;
        redirect_pc_o = 32'd0;
        if_id_we_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;

        if (ext_stall_i) begin
            pc_we_o    = 1'b0;
            if_id_we_o = 1'b0;
            if (ex_redirect_i && !pend_v_q) begin
                pend_v_d  = 1'b1;
                pend_pc_d = ex_target_i;
            end
            state_d = HOLD;
        end else if (pend_v_q) begin
            pc_sel_o      = 2'd1;
            redirect_pc_o = pend_pc_q;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            pend_v_d      = 1'b0;
            state_d       = FLUSH;
        end else if (ex_redirect_i) begin
            pc_sel_o      = 2'd1;
            redirect_pc_o = ex_target_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = FLUSH;
        end else if (state_q == FLUSH) begin
            if_id_flush_o = 1'b1;
            state_d       = RUN;
        end else if (load_use) begin
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            state_d       = RUN;
        end else if (id_jal_i) begin
            pc_sel_o      = 2'd1;
            redirect_pc_o = id_jal_target_i;
            if_id_flush_o = 1'b1;
            state_d       = FLUSH;
        end else begin
            state_d = RUN;
        end

        // Hold the pipeline registers in a safe bubble state during reset.
        if (!rst_n) begin
            pc_we_o       = 1'b0;
            pc_sel_o      = 2'd0;
            redirect_pc_o = 32'd0;
            if_id_we_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pend_v_q  <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

`ifdef FETCH_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters; the async reset keeps them at 0 during reset,
    // so only cycles outside reset are counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_we_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`endif

endmodule
